// File: rtl/chacha20_poly1305_feeder_if.sv
// Upstream word stream into the chacha20/poly1305 block feeder.
// Master drives words; the feeder (slave) returns ready.
interface chacha20_poly1305_feeder_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [2:0]  s_bytes;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output s_bytes,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  s_bytes,
        output s_ready
    );
endinterface

// File: rtl/chacha20_poly1305_feeder.sv
// Packs 32-bit words into zero-padded blocks and sequences the
// core's init/next/done handshakes with a per-wait timeout.
module chacha20_poly1305_feeder #(
    parameter int BLK_WORDS = 16,
    parameter int TIMEOUT   = 1024,
    parameter int LEN_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    chacha20_poly1305_feeder_if.slave up,
    output logic                   core_init,
    output logic                   core_next,
    output logic                   core_done,
    output logic [32*BLK_WORDS-1:0] core_data_in,
    input  logic                   core_ready,
    input  logic                   core_valid,
    input  logic                   core_tag_ok,
    output logic [6:0]             blk_len,
    output logic [LEN_W-1:0]       msg_len,
    output logic                   err_timeout
);
    localparam int IW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int DW = 32 * BLK_WORDS;

    typedef enum logic [2:0] {
        IDLE, INIT, FILL, ISSUE, FIN
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] wait_cnt;
    logic          more;
    logic          phase;

    logic [2:0]    take;
    logic [31:0]   wmask;
    logic [31:0]   wdata;
    logic [6:0]    new_blk;
    logic          last_slot;
    logic          waiting;
    logic          wait_in;
    logic          expired;

    always_comb begin
        take = 3'd4;
        if (up.s_last && up.s_bytes < 3'd4)
            take = up.s_bytes;
        unique case (take)
            3'd0:    wmask = 32'h0000_0000;
            3'd1:    wmask = 32'hff00_0000;
            3'd2:    wmask = 32'hffff_0000;
            3'd3:    wmask = 32'hffff_ff00;
            default: wmask = 32'hffff_ffff;
        endcase
        wdata     = up.s_data & wmask;
        new_blk   = blk_len + 7'(take);
        last_slot = idx == IW'(BLK_WORDS - 1);
        waiting   = state inside {INIT, ISSUE, FIN};
        // phase 0 waits for ready, phase 1 for the result
        wait_in   = core_ready;
        if (phase)
            wait_in = (state == ISSUE) ? core_valid
                                       : core_tag_ok;
        expired   = wait_cnt == CW'(TIMEOUT - 1);
    end

    assign busy       = state != IDLE;
    assign up.s_ready = state == FILL;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            wait_cnt     <= '0;
            more         <= 1'b0;
            phase        <= 1'b0;
            core_init    <= 1'b0;
            core_next    <= 1'b0;
            core_done    <= 1'b0;
            core_data_in <= '0;
            blk_len      <= '0;
            msg_len      <= '0;
            err_timeout  <= 1'b0;
        end else begin
            core_init <= 1'b0;
            core_next <= 1'b0;
            core_done <= 1'b0;
            if (waiting && !wait_in) begin
                if (expired) begin
                    err_timeout <= 1'b1;
                    state       <= IDLE;
                    phase       <= 1'b0;
                    wait_cnt    <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
                unique case (state)
                    IDLE: if (start) begin
                        state        <= INIT;
                        idx          <= '0;
                        more         <= 1'b0;
                        phase        <= 1'b0;
                        core_data_in <= '0;
                        blk_len      <= '0;
                        msg_len      <= '0;
                        err_timeout  <= 1'b0;
                    end
                    INIT: begin
                        core_init <= 1'b1;
                        state     <= FILL;
                    end
                    FILL: if (up.s_valid) begin
                        for (int i = 0; i < BLK_WORDS; i++)
                            if (idx == IW'(i))
                                core_data_in[DW-32*(i+1) +: 32] <= wdata;
                        idx     <= idx + 1'b1;
                        blk_len <= new_blk;
                        msg_len <= msg_len + LEN_W'(take);
                        if (up.s_last) begin
                            more  <= 1'b0;
                            state <= (new_blk != '0) ? ISSUE : FIN;
                        end else if (last_slot) begin
                            more  <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                    ISSUE: if (!phase) begin
                        core_next <= 1'b1;
                        phase     <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (more) begin
                            state        <= FILL;
                            idx          <= '0;
                            blk_len      <= '0;
                            core_data_in <= '0;
                        end else begin
                            state <= FIN;
                        end
                    end
                    FIN: if (!phase) begin
                        core_done <= 1'b1;
                        phase     <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_chacha20_poly1305_feeder.sv
// Bench for chacha20_poly1305_feeder: table vectors, corner sequences
// and random messages against a byte-level block model.
module tb_chacha20_poly1305_feeder;
    localparam int BW = 16;
    localparam int TO = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic core_init, core_next, core_done;
    logic [511:0] core_data_in;
    logic core_ready = 1'b0;
    logic core_valid = 1'b0;
    logic core_tag_ok = 1'b0;
    logic [6:0] blk_len;
    logic [31:0] msg_len;
    logic err_timeout;

    always #5 clk = ~clk;

    chacha20_poly1305_feeder_if sif ();

    chacha20_poly1305_feeder #(
        .BLK_WORDS(BW), .TIMEOUT(TO), .LEN_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .busy(busy), .up(sif.slave),
        .core_init(core_init), .core_next(core_next),
        .core_done(core_done), .core_data_in(core_data_in),
        .core_ready(core_ready), .core_valid(core_valid),
        .core_tag_ok(core_tag_ok), .blk_len(blk_len),
        .msg_len(msg_len), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad = 0;
    int n_init = 0, n_next = 0, n_done = 0;
    int n_overlap = 0, n_unstable = 0;
    logic [511:0] blk_q[$];
    bit hold_low = 1'b0;
    bit rnd_ready = 1'b0;
    logic [31:0] wd[0:63];
    logic [511:0] exp_blk[0:7];

    typedef struct {
        int n; int sb; int nx; int bl; int ml;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string nm,
                       input logic [511:0] act,
                       input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // pulse monitor
    initial forever begin
        @(negedge clk);
        if (int'(core_init) + int'(core_next) + int'(core_done) > 1)
            n_overlap++;
        if (core_init) n_init++;
        if (core_done) n_done++;
        if (core_next) begin
            n_next++;
            blk_q.push_back(core_data_in);
        end
    end

    // core handshake responder
    initial begin
        logic [511:0] d;
        forever begin
            @(negedge clk);
            if (core_next) begin
                d = core_data_in;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (core_data_in !== d) n_unstable++;
                core_valid = 1'b1;
                @(negedge clk);
                core_valid = 1'b0;
            end else if (core_done) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                core_tag_ok = 1'b1;
                @(negedge clk);
                core_tag_ok = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (hold_low) core_ready = 1'b0;
        else if (rnd_ready) core_ready = ($urandom_range(0, 3) != 0);
        else core_ready = 1'b1;
    end

    // reference: flatten message to bytes, cut into 64-byte blocks
    task automatic model(input int n, input int sb,
                         output int len, output int nb, output int lb);
        logic [7:0] bq[$];
        int k;
        bq = {};
        for (int w = 0; w < n; w++) begin
            k = 4;
            if (w == n - 1) k = (sb > 4) ? 4 : sb;
            for (int b = 0; b < k; b++)
                bq.push_back(wd[w][31-8*b -: 8]);
        end
        len = bq.size();
        nb = (len + 63) / 64;
        lb = len - 64 * ((n - 1) / BW);
        for (int j = 0; j < 8; j++) begin
            exp_blk[j] = '0;
            for (int b = 0; b < 64; b++)
                if (64 * j + b < len)
                    exp_blk[j][511-8*b -: 8] = bq[64*j+b];
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_word(input logic [31:0] d,
                              input logic last,
                              input logic [2:0] sb);
        int g;
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = last;
        sif.s_bytes = sb;
        g = 0;
        while (!sif.s_ready && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) chk("s_ready_wait", sif.s_ready, 1);
        @(negedge clk);
        sif.s_valid = 1'b0;
    endtask

    task automatic check_msg(input int n, input int sb,
                             input bit gaps, input string tag,
                             output int gn, output int b0);
        int i0, n0, d0, g, len, nb, lb;
        i0 = n_init; n0 = n_next; d0 = n_done;
        b0 = blk_q.size();
        pulse_start();
        for (int w = 0; w < n; w++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_word(wd[w], w == n - 1,
                       (w == n - 1) ? 3'(sb) : 3'd4);
        end
        g = 0;
        while (busy && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk({tag, " idle"}, busy, 0);
        gn = n_next - n0;
        model(n, sb, len, nb, lb);
        chk({tag, " inits"}, n_init - i0, 1);
        chk({tag, " nexts"}, gn, nb);
        chk({tag, " dones"}, n_done - d0, 1);
        chk({tag, " msg_len"}, msg_len, len);
        chk({tag, " blk_len"}, blk_len, lb);
        chk({tag, " err"}, err_timeout, 0);
        for (int j = 0; j < nb; j++)
            if (b0 + j < blk_q.size())
                chk({tag, " block"}, blk_q[b0+j], exp_blk[j]);
    endtask

    initial begin
        int gn, b0, i0, g;
        logic [511:0] t;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        sif.s_bytes = '0;

        tv[0] = '{16, 4, 1, 64, 64};
        tv[1] = '{20, 2, 2, 14, 78};
        tv[2] = '{1, 0, 0, 0, 0};
        tv[3] = '{17, 0, 1, 0, 64};
        tv[4] = '{1, 4, 1, 4, 4};
        tv[5] = '{3, 7, 1, 12, 12};
        tv[6] = '{32, 4, 2, 64, 128};
        tv[7] = '{33, 1, 3, 1, 129};

        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst s_ready", sif.s_ready, 0);
        chk("rst data", core_data_in, 0);
        chk("rst lens", {blk_len, msg_len}, 0);
        chk("rst flags", {core_init, core_next,
                          core_done, err_timeout}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 64; w++) wd[w] = 32'h0001_0203 + w;
        for (int v = 0; v < 8; v++) begin
            check_msg(tv[v].n, tv[v].sb, 1'b0, $sformatf("vec%0d", v),
                      gn, b0);
            chk($sformatf("vec%0d tnext", v), gn, tv[v].nx);
            chk($sformatf("vec%0d tblk", v), blk_len, tv[v].bl);
            chk($sformatf("vec%0d tmsg", v), msg_len, tv[v].ml);
            if (v == 0 && blk_q.size() > b0) begin
                t = blk_q[b0];
                chk("vec0 word0", t[511:480], 32'h0001_0203);
            end
            if (v == 1 && blk_q.size() > b0 + 1) begin
                t = blk_q[b0+1];
                chk("vec1 word3", t[415:384], 32'h0001_0000);
                chk("vec1 word4", t[383:352], 0);
            end
        end

        // core never ready: timeout, back to idle without init
        hold_low = 1'b1;
        @(negedge clk);
        i0 = n_init;
        pulse_start();
        g = 0;
        while (busy && g < TO + 50) begin
            @(negedge clk);
            g++;
        end
        chk("to busy", busy, 0);
        chk("to err", err_timeout, 1);
        chk("to no init", n_init - i0, 0);
        repeat (5) @(negedge clk);
        chk("to sticky", err_timeout, 1);
        hold_low = 1'b0;
        check_msg(2, 4, 1'b0, "after_to", gn, b0);

        // reset in the middle of filling a block
        pulse_start();
        for (int w = 0; w < 5; w++) drive_word(wd[w], 1'b0, 3'd4);
        chk("mid msg_len", msg_len, 20);
        chk("mid blk_len", blk_len, 20);
        reset_n = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst s_ready", sif.s_ready, 0);
        chk("arst data", core_data_in, 0);
        chk("arst lens", {blk_len, msg_len}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_msg(3, 4, 1'b0, "after_rst", gn, b0);

        // random messages, random gaps and core readiness
        rnd_ready = 1'b1;
        for (int r = 0; r < 25; r++) begin
            for (int w = 0; w < 64; w++) wd[w] = $urandom();
            check_msg($urandom_range(1, 40), $urandom_range(0, 7),
                      1'b1, $sformatf("rnd%0d", r), gn, b0);
        end

        chk("pulse overlap", n_overlap, 0);
        chk("data stable", n_unstable, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
